// File: rtl/poly_sequencer.sv
// rtl/poly_sequencer.sv - Moore FSM sequencing operand load and R = A*X^2 + B*X + C over a shared 8-bit datapath (optional POLY_SEQ_STEP_EN)
module poly_sequencer #(
  parameter int AUTO_RESTART = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
`ifdef POLY_SEQ_STEP_EN
  input  logic       step,
`endif
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_c,
  output logic       ld_x,
  output logic       ld_r,
  output logic       ld_alu_out,
  output logic [1:0] alu_select_a,
  output logic [1:0] alu_select_b,
  output logic       alu_op,
  output logic       busy,
  output logic       done,
  output logic [1:0] operand_idx
);

  typedef enum logic [3:0] {
    S_LOAD_A      = 4'd0,
    S_LOAD_A_WAIT = 4'd1,
    S_LOAD_B      = 4'd2,
    S_LOAD_B_WAIT = 4'd3,
    S_LOAD_C      = 4'd4,
    S_LOAD_C_WAIT = 4'd5,
    S_LOAD_X      = 4'd6,
    S_LOAD_X_WAIT = 4'd7,
    S_CYCLE_0     = 4'd8,
    S_CYCLE_1     = 4'd9,
    S_CYCLE_2     = 4'd10,
    S_CYCLE_3     = 4'd11,
    S_CYCLE_4     = 4'd12,
    S_DONE        = 4'd13
  } state_t;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_X = 2'd3;

  state_t r_state;
  logic   w_adv;

  // Compute steps advance only when allowed; without stepping they run every cycle.
`ifdef POLY_SEQ_STEP_EN
  assign w_adv = step;
`else
  assign w_adv = 1'b1;
`endif

  // State register: operand handshake, microprogram sequencing and restart handling.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_LOAD_A;
    end else begin
      case (r_state)
        S_LOAD_A:      if (go)  r_state <= S_LOAD_A_WAIT;
        S_LOAD_A_WAIT: if (!go) r_state <= S_LOAD_B;
        S_LOAD_B:      if (go)  r_state <= S_LOAD_B_WAIT;
        S_LOAD_B_WAIT: if (!go) r_state <= S_LOAD_C;
        S_LOAD_C:      if (go)  r_state <= S_LOAD_C_WAIT;
        S_LOAD_C_WAIT: if (!go) r_state <= S_LOAD_X;
        S_LOAD_X:      if (go)  r_state <= S_LOAD_X_WAIT;
        S_LOAD_X_WAIT: if (!go) r_state <= S_CYCLE_0;
        S_CYCLE_0:     if (w_adv) r_state <= S_CYCLE_1;
        S_CYCLE_1:     if (w_adv) r_state <= S_CYCLE_2;
        S_CYCLE_2:     if (w_adv) r_state <= S_CYCLE_3;
        S_CYCLE_3:     if (w_adv) r_state <= S_CYCLE_4;
        S_CYCLE_4:     if (w_adv) r_state <= S_DONE;
        S_DONE: begin
          if (AUTO_RESTART != 0) begin
            r_state <= S_LOAD_A;
          end else if (go) begin
            // The restart press is swallowed here so it does not also load A.
            r_state <= S_LOAD_A_WAIT;
          end
        end
        default:       r_state <= S_LOAD_A;
      endcase
    end
  end

  // Output decode from the current state; load strobes in compute are gated by w_adv.
  always_comb begin
    ld_a         = 1'b0;
    ld_b         = 1'b0;
    ld_c         = 1'b0;
    ld_x         = 1'b0;
    ld_r         = 1'b0;
    ld_alu_out   = 1'b0;
    alu_select_a = SEL_A;
    alu_select_b = SEL_A;
    alu_op       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    operand_idx  = 2'd0;
    case (r_state)
      S_LOAD_A: begin
        ld_a        = 1'b1;
        operand_idx = 2'd0;
      end
      S_LOAD_B: begin
        ld_b        = 1'b1;
        operand_idx = 2'd1;
      end
      S_LOAD_C: begin
        ld_c        = 1'b1;
        operand_idx = 2'd2;
      end
      S_LOAD_X: begin
        ld_x        = 1'b1;
        operand_idx = 2'd3;
      end
      S_CYCLE_0, S_CYCLE_1: begin
        alu_select_a = SEL_A;
        alu_select_b = SEL_X;
        alu_op       = 1'b1;
        ld_a         = w_adv;
        ld_alu_out   = 1'b1;
        busy         = 1'b1;
      end
      S_CYCLE_2: begin
        alu_select_a = SEL_B;
        alu_select_b = SEL_X;
        alu_op       = 1'b1;
        ld_b         = w_adv;
        ld_alu_out   = 1'b1;
        busy         = 1'b1;
      end
      S_CYCLE_3: begin
        alu_select_a = SEL_A;
        alu_select_b = SEL_B;
        alu_op       = 1'b0;
        ld_a         = w_adv;
        ld_alu_out   = 1'b1;
        busy         = 1'b1;
      end
      S_CYCLE_4: begin
        alu_select_a = SEL_A;
        alu_select_b = SEL_C;
        alu_op       = 1'b0;
        ld_r         = w_adv;
        busy         = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      S_LOAD_A_WAIT, S_LOAD_B_WAIT, S_LOAD_C_WAIT, S_LOAD_X_WAIT: begin
        operand_idx = 2'd0;
      end
      default: begin
        // Unused encodings present reset-value outputs for their single cycle.
        ld_a = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_poly_sequencer.sv
// tb/tb_poly_sequencer.sv - directed self-checking bench for poly_sequencer with a reference datapath
module tb_poly_sequencer;

  logic       clk;
  logic       resetn;
  logic       go;
  logic       go2;
  logic       step;
  logic [7:0] data_in;

  logic       ld_a, ld_b, ld_c, ld_x, ld_r, ld_alu_out, alu_op, busy, done;
  logic [1:0] alu_select_a, alu_select_b, operand_idx;

  logic       ld_a2, ld_b2, ld_c2, ld_x2, ld_r2, ld_alu_out2, alu_op2, busy2, done2;
  logic [1:0] alu_select_a2, alu_select_b2, operand_idx2;

  int n_run  = 0;
  int n_fail = 0;
  int n_ldr  = 0;
  int snap;

  poly_sequencer #(.AUTO_RESTART(1)) u_dut (
    .clk(clk), .resetn(resetn), .go(go),
`ifdef POLY_SEQ_STEP_EN
    .step(step),
`endif
    .ld_a(ld_a), .ld_b(ld_b), .ld_c(ld_c), .ld_x(ld_x), .ld_r(ld_r),
    .ld_alu_out(ld_alu_out), .alu_select_a(alu_select_a), .alu_select_b(alu_select_b),
    .alu_op(alu_op), .busy(busy), .done(done), .operand_idx(operand_idx)
  );

  poly_sequencer #(.AUTO_RESTART(0)) u_dut_hold (
    .clk(clk), .resetn(resetn), .go(go2),
`ifdef POLY_SEQ_STEP_EN
    .step(step),
`endif
    .ld_a(ld_a2), .ld_b(ld_b2), .ld_c(ld_c2), .ld_x(ld_x2), .ld_r(ld_r2),
    .ld_alu_out(ld_alu_out2), .alu_select_a(alu_select_a2), .alu_select_b(alu_select_b2),
    .alu_op(alu_op2), .busy(busy2), .done(done2), .operand_idx(operand_idx2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference datapath driven by the first instance's strobes.
  logic [7:0] m_a, m_b, m_c, m_x, m_r, w_opa, w_opb, w_alu;

  function automatic logic [7:0] pick(input logic [1:0] s, input logic [7:0] a, b, c, x);
    case (s)
      2'd0: pick = a;
      2'd1: pick = b;
      2'd2: pick = c;
      default: pick = x;
    endcase
  endfunction

  always_comb begin
    w_opa = pick(alu_select_a, m_a, m_b, m_c, m_x);
    w_opb = pick(alu_select_b, m_a, m_b, m_c, m_x);
    w_alu = alu_op ? 8'(w_opa * w_opb) : 8'(w_opa + w_opb);
  end

  always @(posedge clk) begin
    if (ld_a) m_a <= ld_alu_out ? w_alu : data_in;
    if (ld_b) m_b <= ld_alu_out ? w_alu : data_in;
    if (ld_c) m_c <= data_in;
    if (ld_x) m_x <= data_in;
    if (ld_r) m_r <= w_alu;
    if (ld_r) n_ldr <= n_ldr + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_op(input logic [7:0] v, input logic [1:0] idx);
    check("load_idx", {30'd0, operand_idx}, {30'd0, idx});
    data_in = v;
    go = 1'b1;
    tick();
    go = 1'b0;
    data_in = 8'hEE;
    tick();
  endtask

  task automatic run_vector(input logic [7:0] a, b, c, x, input logic [7:0] exp);
    load_op(a, 2'd0);
    load_op(b, 2'd1);
    load_op(c, 2'd2);
    load_op(x, 2'd3);
    check("c0_strobes", {28'd0, ld_a, ld_alu_out, alu_op, alu_select_b == 2'd3}, 32'hF);
    for (int k = 0; k < 5; k++) begin
      check("busy_compute", {31'd0, busy}, 32'd1);
      tick();
    end
    check("done_high", {31'd0, done}, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    check("result_r", {24'd0, m_r}, {24'd0, exp});
    tick();
    check("auto_restart", {30'd0, ld_a, done}, 32'h2);
  endtask

  initial begin
    resetn  = 1'b0;
    go      = 1'b0;
    go2     = 1'b0;
    step    = 1'b1;
    data_in = 8'h00;
    tick();
    tick();
    check("rst_strobes", {27'd0, ld_a, ld_b, ld_c, ld_x, ld_r}, 32'h10);
    check("rst_selects", {27'd0, ld_alu_out, alu_select_a, alu_select_b} , 32'h0);
    check("rst_status", {27'd0, alu_op, busy, done, operand_idx}, 32'h0);
    resetn = 1'b1;

    // Hold-in-DONE instance: load four operands, then observe DONE persisting.
    for (int i = 0; i < 4; i++) begin
      go2 = 1'b1;
      tick();
      go2 = 1'b0;
      tick();
    end
    check("hold_busy", {31'd0, busy2}, 32'd1);
    repeat (5) tick();
    for (int i = 0; i < 10; i++) begin
      check("hold_done", {31'd0, done2}, 32'd1);
      tick();
    end
    go2 = 1'b1;
    tick();
    check("hold_restart", {28'd0, done2, busy2, operand_idx2}, 32'h0);
    check("hold_no_lda", {31'd0, ld_a2}, 32'd0);
    go2 = 1'b0;
    tick();
    check("hold_to_ldb", {29'd0, ld_b2, operand_idx2}, 32'h5);

    run_vector(8'd2, 8'd3, 8'd4, 8'd5, 8'h45);
    run_vector(8'd3, 8'd7, 8'd200, 8'd10, 8'h3A);
    run_vector(8'd1, 8'd0, 8'd0, 8'd16, 8'h00);

    // go held high through LOAD_B must not skip an operand.
    load_op(8'd2, 2'd0);
    check("ldb_idx", {30'd0, operand_idx}, 32'd1);
    go = 1'b1;
    data_in = 8'd3;
    repeat (20) tick();
    check("held_idx", {30'd0, operand_idx}, 32'd0);
    check("held_strobes", {30'd0, ld_b, ld_c}, 32'd0);
    go = 1'b0;
    tick();
    check("after_hold", {29'd0, ld_c, operand_idx}, 32'h6);
    check("held_b_value", {24'd0, m_b}, 32'd3);

    // Reset in the middle of compute aborts without a result load.
    load_op(8'd4, 2'd2);
    load_op(8'd5, 2'd3);
    tick();
    tick();
    check("in_cycle2", {29'd0, ld_b, ld_alu_out, busy}, 32'h7);
    snap = n_ldr;
    resetn = 1'b0;
    tick();
    check("mid_rst", {28'd0, ld_a, busy, operand_idx}, 32'h8);
    resetn = 1'b1;
    repeat (8) tick();
    check("mid_rst_no_ldr", n_ldr, snap);
    check("mid_rst_idle", {30'd0, ld_a, busy}, 32'h2);

`ifdef POLY_SEQ_STEP_EN
    load_op(8'd2, 2'd0);
    load_op(8'd3, 2'd1);
    load_op(8'd4, 2'd2);
    load_op(8'd5, 2'd3);
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_no_ld", {30'd0, ld_a, ld_r}, 32'd0);
      check("stall_busy_op", {29'd0, busy, alu_op, alu_select_b == 2'd3}, 32'h7);
      tick();
    end
    check("stall_a_kept", {24'd0, m_a}, 32'd10);
    repeat (3) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
    end
    step = 1'b1;
    tick();
    check("step_done", {31'd0, done}, 32'd1);
    check("step_result", {24'd0, m_r}, 32'h45);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
